// File: rtl/rs_stream_encoder_if.sv
// Streaming bus for the RS(7,5) encoder over GF(8).
//   in_valid/in_ready/in_sym      : message symbol input handshake
//   out_valid/out_ready/out_sym   : codeword symbol output handshake
//   out_first/out_last            : frame delimiters on the output stream
//   codeword/cw_valid             : packed frame plus one-cycle completion strobe
// master = producer/consumer side, slave = encoder side.
interface rs_stream_encoder_if #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SYMBOL_WIDTH-1:0]   in_sym;
    logic                      out_valid;
    logic                      out_ready;
    logic [SYMBOL_WIDTH-1:0]   out_sym;
    logic                      out_first;
    logic                      out_last;
    logic [N*SYMBOL_WIDTH-1:0] codeword;
    logic                      cw_valid;

    modport master (
        output in_valid, in_sym, out_ready,
        input  in_ready, out_valid, out_sym, out_first, out_last, codeword, cw_valid
    );

    modport slave (
        input  in_valid, in_sym, out_ready,
        output in_ready, out_valid, out_sym, out_first, out_last, codeword, cw_valid
    );
endinterface

// File: rtl/rs_stream_encoder.sv
// Systematic RS(7,5) streaming encoder over GF(8) (x^3+x+1, alpha = 3'b010).
// Message symbols m4..m0 stream through unchanged, followed by parity p1, p0
// computed with g(x) = x^2 + 6x + 3. One output register stage.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : rs_stream_encoder_if.slave (input/output streams, packed codeword)
module rs_stream_encoder #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7,
    parameter int K            = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    rs_stream_encoder_if.slave   bus
);
    localparam int W = SYMBOL_WIDTH;

    localparam logic [1:0] ST_MSG  = 2'd0;
    localparam logic [1:0] ST_PAR1 = 2'd1;
    localparam logic [1:0] ST_PAR0 = 2'd2;

    localparam logic [2:0] LAST_CNT = 3'(K - 1);

    // Multiply by alpha: x^3 folds back to x+1.
    function automatic logic [W-1:0] gf_mul2(input logic [W-1:0] a);
        return {a[1], a[0] ^ a[2], a[2]};
    endfunction

    function automatic logic [W-1:0] gf_mul3(input logic [W-1:0] a);
        return gf_mul2(a) ^ a;
    endfunction

    // 6 = alpha * (alpha + 1)
    function automatic logic [W-1:0] gf_mul6(input logic [W-1:0] a);
        return gf_mul2(gf_mul3(a));
    endfunction

    logic [1:0]           r_state;
    logic [2:0]           r_cnt;
    logic [W-1:0]         r_r1, r_r0;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_sym;
    logic                 r_out_first, r_out_last;
    // Holds the six symbols loaded before p0; p0 is appended on the final load.
    logic [(N-1)*W-1:0]   r_asm;
    logic [N*W-1:0]       r_codeword;
    logic                 r_cw_valid;

    logic                 w_slot_free;
    logic                 w_in_ready;
    logic [W-1:0]         w_f;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_in_ready  = (r_state == ST_MSG) && w_slot_free;
    assign w_f         = bus.in_sym ^ r_r1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_MSG;
            r_cnt       <= '0;
            r_r1        <= '0;
            r_r0        <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_asm       <= '0;
            r_codeword  <= '0;
            r_cw_valid  <= 1'b0;
        end else begin
            r_cw_valid <= 1'b0;
            if (w_slot_free) begin
                // Slot drains unless one of the branches below reloads it.
                r_out_valid <= 1'b0;
                case (r_state)
                    ST_MSG: begin
                        if (bus.in_valid) begin
                            r_out_valid <= 1'b1;
                            r_out_sym   <= bus.in_sym;
                            r_out_first <= (r_cnt == 3'd0);
                            r_out_last  <= 1'b0;
                            r_r1        <= r_r0 ^ gf_mul6(w_f);
                            r_r0        <= gf_mul3(w_f);
                            r_asm       <= {r_asm[(N-2)*W-1:0], bus.in_sym};
                            if (r_cnt == LAST_CNT) begin
                                r_cnt   <= '0;
                                r_state <= ST_PAR1;
                            end else begin
                                r_cnt   <= r_cnt + 3'd1;
                            end
                        end
                    end
                    ST_PAR1: begin
                        r_out_valid <= 1'b1;
                        r_out_sym   <= r_r1;
                        r_out_first <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_asm       <= {r_asm[(N-2)*W-1:0], r_r1};
                        r_state     <= ST_PAR0;
                    end
                    ST_PAR0: begin
                        r_out_valid <= 1'b1;
                        r_out_sym   <= r_r0;
                        r_out_first <= 1'b0;
                        r_out_last  <= 1'b1;
                        r_codeword  <= {r_asm, r_r0};
                        r_cw_valid  <= 1'b1;
                        r_r1        <= '0;
                        r_r0        <= '0;
                        r_state     <= ST_MSG;
                    end
                    default: r_state <= ST_MSG;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sym   = r_out_sym;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;
    assign bus.codeword  = r_codeword;
    assign bus.cw_valid  = r_cw_valid;
endmodule

// File: tb/tb_rs_stream_encoder.sv
module tb_rs_stream_encoder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs_stream_encoder_if #(.SYMBOL_WIDTH(3), .N(7)) bus ();

    rs_stream_encoder #(.SYMBOL_WIDTH(3), .N(7), .K(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] sym;
        logic       first;
        logic       last;
        logic       dc;      // parity of a random frame: value checked via codeword
    } sym_exp_t;

    typedef struct {
        logic        exact;
        logic [20:0] cw;
        logic [14:0] msg;
    } cw_exp_t;

    sym_exp_t sym_q[$];
    cw_exp_t  cw_q[$];
    int       last_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Generic GF(8) multiply (shift/add, reduce by x^3+x+1).
    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p = '0;
        for (int i = 0; i < 3; i++) if (b[i]) p ^= 5'({a} << i);
        for (int i = 4; i >= 3; i--) if (p[i]) p ^= 5'(5'b01011 << (i - 3));
        return p[2:0];
    endfunction

    function automatic logic [2:0] ceval(input logic [20:0] c, input logic [2:0] x);
        logic [2:0] acc = '0;
        for (int i = 6; i >= 0; i--) acc = gmul(acc, x) ^ c[3*i +: 3];
        return acc;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sym_q.size() == 0) begin
                    chk("unexpected_out_sym", 32'(bus.out_sym), 32'hFFFF);
                end else begin
                    sym_exp_t e;
                    e = sym_q.pop_front();
                    if (!e.dc) chk("out_sym", 32'(bus.out_sym), 32'(e.sym));
                    chk("out_first", 32'(bus.out_first), 32'(e.first));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                end
            end
            if (bus.cw_valid) begin
                if (cw_q.size() == 0) begin
                    chk("unexpected_cw_valid", 32'(bus.codeword), 32'hFFFF);
                end else begin
                    cw_exp_t c;
                    c = cw_q.pop_front();
                    if (c.exact) begin
                        chk("codeword", 32'(bus.codeword), 32'(c.cw));
                    end else begin
                        chk("cw_msg", 32'(bus.codeword[20:6]), 32'(c.msg));
                        chk("syn_a1", 32'(ceval(bus.codeword, 3'd2)), 32'd0);
                        chk("syn_a2", 32'(ceval(bus.codeword, 3'd4)), 32'd0);
                    end
                end
            end
        end
    end

    task automatic accept_sym(input logic [2:0] s, output int acc_cyc);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
    endtask

    // msg packed m4 in [14:12]; bp=1 stalls the consumer 3 cycles after symbol 2.
    task automatic send_frame(input logic [14:0] msg, input logic exact, input logic [20:0] cw,
                              input bit bp, input bit tp);
        int ac;
        for (int i = 0; i < 5; i++)
            sym_q.push_back('{msg[14-3*i -: 3], (i == 0), 1'b0, 1'b0});
        sym_q.push_back('{cw[5:3], 1'b0, 1'b0, !exact});
        sym_q.push_back('{cw[2:0], 1'b0, 1'b1, !exact});
        cw_q.push_back('{exact, cw, msg});
        for (int i = 0; i < 5; i++) begin
            accept_sym(msg[14-3*i -: 3], ac);
            if (i == 0) begin
                if (tp && last_start >= 0) chk("frame_period", 32'(ac - last_start), 32'd7);
                last_start = ac;
            end
            if (bp && i == 1) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_sym    = msg[8:6];
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("bp_out_sym", 32'(bus.out_sym), 32'(msg[11:9]));
                    chk("bp_out_first", 32'(bus.out_first), 32'd0);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sym_q.size() != 0 || cw_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_sym_q", 32'(sym_q.size()), 32'd0);
        chk("drain_cw_q", 32'(cw_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ac;
        logic [14:0] m;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.out_ready = 1'b1;
        last_start    = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sym", 32'(bus.out_sym), 32'd0);
        chk("rst_out_first", 32'(bus.out_first), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_codeword", 32'(bus.codeword), 32'd0);
        chk("rst_cw_valid", 32'(bus.cw_valid), 32'd0);
        @(posedge clk);
        #1;

        // Directed frames
        send_frame({3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1'b1, 21'o0000163, 1'b0, 1'b0);
        drain();
        send_frame({3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 1'b1, 21'o0001011, 1'b0, 1'b0);
        drain();
        send_frame({3'd1, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b1, 21'o1000062, 1'b0, 1'b0);
        drain();
        send_frame({3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1'b1, 21'o0000163, 1'b1, 1'b0);
        drain();

        // Codeword holds and output drains when idle
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("cw_hold", 32'(bus.codeword), 32'(21'o0000163));
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset after 3 accepted symbols of a frame
        sym_q.push_back('{3'd5, 1'b1, 1'b0, 1'b0});
        sym_q.push_back('{3'd6, 1'b0, 1'b0, 1'b0});
        sym_q.push_back('{3'd7, 1'b0, 1'b0, 1'b0});
        accept_sym(3'd5, ac);
        accept_sym(3'd6, ac);
        accept_sym(3'd7, ac);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;   // ignored: reset wins
        bus.in_sym   = 3'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_codeword", 32'(bus.codeword), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_frame({3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1'b1, 21'o0000163, 1'b0, 1'b0);
        drain();

        // Random back-to-back frames
        last_start = -1;
        for (int f = 0; f < 1000; f++) begin
            m = 15'($urandom);
            send_frame(m, 1'b0, {m, 6'd0}, 1'b0, 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
